// File: rtl/fcvt_int2fp_pipe.sv
// Pipelined integer-to-float converter with IEEE-754 rounding and inexact flag.
// Three stages (operand prep, normalise, round/pack) behind a valid/ready handshake.
module fcvt_int2fp_pipe #(
  parameter int XLEN  = 64,
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     in_signed,
  input  logic                     in_word,
  input  logic [2:0]               in_rm,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic                     out_nx,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LW = $clog2(XLEN);
  localparam int GI = XLEN - 2 - MAN_W;
  localparam logic [EXP_W-1:0] BIAS = {1'b0, {(EXP_W-1){1'b1}}};

  logic v1, v2, v3;
  logic en1, en2, en3;

  logic              s1_sign, s1_zero;
  logic [XLEN-1:0]   s1_mag;
  logic [LW-1:0]     s1_lead;
  logic [2:0]        s1_rm;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_sign, s2_zero, s2_g, s2_s;
  logic [MAN_W-1:0]  s2_frac;
  logic [EXP_W-1:0]  s2_exp;
  logic [2:0]        s2_rm;
  logic [TAG_W-1:0]  s2_tag;

  assign en3       = ~v3 | out_ready;
  assign en2       = ~v2 | en3;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // S1: source select, sign/magnitude, leading-one position
  logic [31:0]     word_lo;
  logic [XLEN-1:0] src_word, src, mag;
  logic            sign;
  logic [LW-1:0]   lead;

  assign word_lo  = in_data[31:0];
  assign src_word = in_signed ? XLEN'(signed'(word_lo)) : XLEN'(word_lo);
  assign src      = (XLEN > 32 && in_word) ? src_word : in_data;
  assign sign     = in_signed & src[XLEN-1];
  assign mag      = sign ? (~src + 1'b1) : src;

  always_comb begin
    lead = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (mag[i]) lead = LW'(i);
    end
  end

  // S2: left-justify the leading one, split into fraction/guard/sticky
  logic [LW-1:0]   shamt;
  logic [XLEN-1:0] norm, sticky_mask;
  assign shamt       = LW'(XLEN - 1) - s1_lead;
  assign norm        = s1_mag << shamt;
  assign sticky_mask = (XLEN'(1) << GI) - XLEN'(1);

  // S3: rounding increment; a carry out of the fraction bumps the exponent
  logic             inc;
  logic [MAN_W:0]   rsum;
  logic [EXP_W+MAN_W:0] packed_res;

  always_comb begin
    inc = 1'b0;
    case (s2_rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s2_sign & (s2_g | s2_s);
      3'b011:  inc = ~s2_sign & (s2_g | s2_s);
      3'b100:  inc = s2_g;
      default: inc = s2_g & (s2_s | s2_frac[0]);
    endcase
  end

  assign rsum = {1'b0, s2_frac} + {{MAN_W{1'b0}}, inc};

  always_comb begin
    packed_res = {s2_sign, s2_exp + EXP_W'(rsum[MAN_W]), rsum[MAN_W-1:0]};
    if (s2_zero) packed_res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
      s1_lead  <= '0;
      s1_rm    <= '0;
      s1_tag   <= '0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_g     <= 1'b0;
      s2_s     <= 1'b0;
      s2_frac  <= '0;
      s2_exp   <= '0;
      s2_rm    <= '0;
      s2_tag   <= '0;
      out_data <= '0;
      out_nx   <= 1'b0;
      out_tag  <= '0;
    end else begin
      if (flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        if (en1) v1 <= in_valid;
        if (en2) v2 <= v1;
        if (en3) v3 <= v2;
      end
      if (en1) begin
        s1_sign <= sign;
        s1_zero <= (mag == '0);
        s1_mag  <= mag;
        s1_lead <= lead;
        s1_rm   <= in_rm;
        s1_tag  <= in_tag;
      end
      if (en2) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_frac <= norm[XLEN-2 -: MAN_W];
        s2_g    <= norm[GI];
        s2_s    <= |(norm & sticky_mask);
        s2_exp  <= EXP_W'(s1_lead) + BIAS;
        s2_rm   <= s1_rm;
        s2_tag  <= s1_tag;
      end
      if (en3) begin
        out_data <= packed_res;
        out_nx   <= ~s2_zero & (s2_g | s2_s);
        out_tag  <= s2_tag;
      end
    end
  end

endmodule
